beam_direction_decoder: RTL and testbench

Decodes two adjacent beam-break sensors at a doorway into direction events. Emits a single-cycle `inc` per completed entry and a single-cycle `dec` per completed exit. These pulses drive the `inc`/`dec` inputs of the occupancy counter directly; saturation is handled there, not here. Partial passages, reversals and illegal sensor sequences never produce a pulse.

---
 rtl/beam_decoder_pkg.sv | 22 ++
 rtl/beam_direction_decoder_debounce.sv | 52 +++++
 rtl/beam_direction_decoder.sv | 111 +++++++++++
 tb/tb_beam_direction_decoder.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/beam_decoder_pkg.sv
// beam_decoder_pkg: shared types for the doorway beam direction decoder.
//   state_t  - direction FSM states
//   S_*      - sensor pair encodings, s = {a, b}
package beam_decoder_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EN_A  = 3'd1,
        EN_AB = 3'd2,
        EN_B  = 3'd3,
        EX_B  = 3'd4,
        EX_BA = 3'd5,
        EX_A  = 3'd6,
        FAULT = 3'd7
    } state_t;

    localparam logic [1:0] S_NONE = 2'b00;
    localparam logic [1:0] S_A    = 2'b10;
    localparam logic [1:0] S_AB   = 2'b11;
    localparam logic [1:0] S_B    = 2'b01;

endpackage

// File: rtl/beam_direction_decoder_debounce.sv
// sensor_debounce: 2-flop synchronizer for one asynchronous beam input,
// followed by an optional stability filter (compiled only when the macro
// BEAM_DEBOUNCE_EN is defined).
// Ports:
//   clk   - clock
//   reset - synchronous active-high reset
//   din   - raw sensor pin (asynchronous)
//   dout  - synchronized (and, if enabled, filtered) sensor value
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [1:0] sync;

    always_ff @(posedge clk) begin
        if (reset) sync <= 2'b00;
        else       sync <= {sync[0], din};
    end

`ifdef BEAM_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt;
    logic             filt;

    // cnt tracks how many consecutive samples have disagreed with filt;
    // the update fires on the DEBOUNCE_CYCLES-th disagreeing sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            filt <= 1'b0;
        end else if (sync[1] == filt) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt  <= '0;
            filt <= sync[1];
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign dout = filt;
`else
    assign dout = sync[1];
`endif

endmodule

// File: rtl/beam_direction_decoder.sv
// beam_direction_decoder: turns two adjacent beam-break sensors into
// single-cycle entry (inc) / exit (dec) pulses. Partial passages, reversals
// and illegal jumps never pulse. Optional input debounce via BEAM_DEBOUNCE_EN.
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   sensor_a, sensor_b - outer / inner beam, 1 = broken, asynchronous
//   inc, dec           - one-cycle pulse per completed entry / exit
//   busy               - FSM not in IDLE
//   fault              - FSM in FAULT
module beam_direction_decoder
    import beam_decoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic sensor_a,
    input  logic sensor_b,
    output logic inc,
    output logic dec,
    output logic busy,
    output logic fault
);

    logic       a_s, b_s;
    logic [1:0] s;
    state_t     state, next;
    logic       inc_d, dec_d;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk(clk), .reset(reset), .din(sensor_a), .dout(a_s)
    );
    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk(clk), .reset(reset), .din(sensor_b), .dout(b_s)
    );

    assign s = {a_s, b_s};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            inc   <= 1'b0;
            dec   <= 1'b0;
            busy  <= 1'b0;
            fault <= 1'b0;
        end else begin
            state <= next;
            inc   <= inc_d;
            dec   <= dec_d;
            // decode from next so busy/fault line up with the state register
            busy  <= (next != IDLE);
            fault <= (next == FAULT);
        end
    end

    // Each state lists only its legal neighbours; the opposite (two-bit) jump
    // is the FAULT entry, and the state's own encoding holds.
    always_comb begin
        next  = state;
        inc_d = 1'b0;
        dec_d = 1'b0;
        case (state)
            IDLE: begin
                if      (s == S_A)  next = EN_A;
                else if (s == S_B)  next = EX_B;
                else if (s == S_AB) next = FAULT;
            end
            EN_A: begin
                if      (s == S_AB)   next = EN_AB;
                else if (s == S_NONE) next = IDLE;
                else if (s == S_B)    next = FAULT;
            end
            EN_AB: begin
                if      (s == S_B)    next = EN_B;
                else if (s == S_A)    next = EN_A;
                else if (s == S_NONE) next = FAULT;
            end
            EN_B: begin
                if (s == S_NONE) begin
                    next  = IDLE;
                    inc_d = 1'b1;
                end
                else if (s == S_AB) next = EN_AB;
                else if (s == S_A)  next = FAULT;
            end
            EX_B: begin
                if      (s == S_AB)   next = EX_BA;
                else if (s == S_NONE) next = IDLE;
                else if (s == S_A)    next = FAULT;
            end
            EX_BA: begin
                if      (s == S_A)    next = EX_A;
                else if (s == S_B)    next = EX_B;
                else if (s == S_NONE) next = FAULT;
            end
            EX_A: begin
                if (s == S_NONE) begin
                    next  = IDLE;
                    dec_d = 1'b1;
                end
                else if (s == S_AB) next = EX_BA;
                else if (s == S_B)  next = FAULT;
            end
            FAULT: begin
                if (s == S_NONE) next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_beam_direction_decoder.sv
module tb_beam_direction_decoder;

`ifdef BEAM_DEBOUNCE_EN
    localparam int DC   = 4;
    localparam int HOLD = 6;
`else
    localparam int DC   = 0;
    localparam int HOLD = 5;
`endif

    logic clk = 1'b0;
    logic reset, sensor_a, sensor_b;
    logic inc, dec, busy, fault;

    beam_direction_decoder #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .sensor_a(sensor_a), .sensor_b(sensor_b),
        .inc(inc), .dec(dec), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    int vecs = 0, errs = 0;
    int cyc = 0, mark = 0, inc_cyc = 0;
    int n_inc = 0, n_dec = 0, viol = 0;
    bit saw_fault = 0, saw_busy = 0, prev_pulse = 0;

    // sampled 1 time unit after each active edge
    always @(posedge clk) begin
        #1;
        cyc++;
        if (inc) begin n_inc++; inc_cyc = cyc; end
        if (dec) n_dec++;
        if (fault) saw_fault = 1;
        if (busy) saw_busy = 1;
        if ((inc && dec) || (prev_pulse && (inc || dec))) viol++;
        prev_pulse = inc || dec;
    end

    task automatic chk(input string tag, input int got, input int exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic apply(input logic [1:0] s, input int n);
        @(negedge clk);
        {sensor_a, sensor_b} = s;
        mark = cyc;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic clr();
        @(negedge clk);
        n_inc = 0; n_dec = 0; saw_fault = 0; saw_busy = 0;
    endtask

    initial begin
        reset = 1'b1; sensor_a = 1'b0; sensor_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_inc", inc, 0);
        chk("rst_dec", dec, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fault", fault, 0);
        @(negedge clk) reset = 1'b0;

        // entry
        clr();
        apply(2'b00, HOLD); apply(2'b10, HOLD); apply(2'b11, HOLD);
        apply(2'b01, HOLD); apply(2'b00, 1);
        begin : entry_mark
            int m;
            m = mark;
            repeat (12) @(negedge clk);
            chk("entry_inc_cnt", n_inc, 1);
            chk("entry_inc_lat", inc_cyc - m, 3 + DC);
        end
        chk("entry_dec_cnt", n_dec, 0);
        chk("entry_busy_end", busy, 0);

        // exit
        clr();
        apply(2'b01, HOLD); apply(2'b11, HOLD); apply(2'b10, HOLD);
        apply(2'b00, HOLD + 8);
        chk("exit_dec_cnt", n_dec, 1);
        chk("exit_inc_cnt", n_inc, 0);
        chk("exit_busy_end", busy, 0);

        // reversal / abort
        clr();
        apply(2'b10, HOLD); apply(2'b11, HOLD); apply(2'b10, HOLD);
        apply(2'b00, HOLD + 8);
        chk("abort_inc", n_inc, 0);
        chk("abort_dec", n_dec, 0);
        chk("abort_fault", saw_fault, 0);
        clr();
        apply(2'b10, HOLD); apply(2'b11, HOLD); apply(2'b01, HOLD);
        apply(2'b11, HOLD); apply(2'b01, HOLD); apply(2'b00, HOLD + 8);
        chk("rev_inc_cnt", n_inc, 1);
        chk("rev_dec_cnt", n_dec, 0);

        // illegal jump 00 -> 11
        clr();
        apply(2'b11, HOLD + 6);
        chk("ill_fault_hi", fault, 1);
        chk("ill_busy_hi", busy, 1);
        apply(2'b00, HOLD + 8);
        chk("ill_fault_lo", fault, 0);
        chk("ill_busy_lo", busy, 0);
        chk("ill_inc", n_inc, 0);
        chk("ill_dec", n_dec, 0);

        // reset mid-passage
        clr();
        apply(2'b10, HOLD); apply(2'b11, HOLD);
        @(negedge clk);
        {sensor_a, sensor_b} = 2'b01;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_inc", inc, 0);
        chk("midrst_dec", dec, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_fault", fault, 0);
        @(negedge clk) reset = 1'b0;
        repeat (HOLD + 6) @(negedge clk);
        chk("midrst_exb_busy", busy, 1);
        apply(2'b00, HOLD + 8);
        chk("midrst_busy_end", busy, 0);
        chk("midrst_inc_cnt", n_inc, 0);
        chk("midrst_dec_cnt", n_dec, 0);
        chk("midrst_fault_seen", saw_fault, 0);

`ifdef BEAM_DEBOUNCE_EN
        // 3-cycle glitch on sensor_a must be filtered out
        clr();
        apply(2'b10, 3); apply(2'b00, 12);
        chk("glitch_busy", saw_busy, 0);
        chk("glitch_inc", n_inc, 0);
`endif

        chk("pulse_rules", viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=0 exp=1");
        $fatal(1);
    end

endmodule
